// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: top-level match sequencer for the Pong design.
// Walks IDLE -> SERVE -> PLAY -> POINT/OVER, keeps both scores, picks the
// serve direction and the winner. It also drives the paddle/ball resets and
// the ball enable. Time is counted in frames (frame_tick).
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   frame_tick                one-cycle pulse per video frame
//   start_btn                 start/restart button level (rising edge used)
//   miss_left, miss_right     one-cycle miss pulses from the ball block
//   paddle_rst_n, ball_rst_n  active-low resets to paddle and ball blocks
//   ball_enable               1 = ball may move
//   serve_dir                 0 = serve left, 1 = serve right
//   score_l, score_r          player scores
//   winner                    00 none, 01 left, 10 right
//   state                     IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       paddle_rst_n,
    output logic       ball_rst_n,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_q;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       dir_q, dir_d;
    logic       paddle_q, ball_rst_q, enable_q;

    logic       start_edge;
    logic [3:0] inc_l, inc_r;

    assign start_edge = start_btn & ~start_q;
    assign inc_l      = score_l_q + 4'd1;
    assign inc_r      = score_r_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        dir_d     = dir_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_d   = S_SERVE;
                    cnt_d     = SERVE_CNT;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == 8'd1) begin
                        state_d = S_PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // A miss wins over a coincident frame_tick, which is simply dropped.
                if (miss_left && miss_right) begin
                    state_d = S_POINT;
                    cnt_d   = POINT_CNT;
                end else if (miss_left) begin
                    score_r_d = inc_r;
                    dir_d     = 1'b0;
                    if (inc_r == WIN_VAL) begin
                        state_d  = S_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = S_POINT;
                        cnt_d   = POINT_CNT;
                    end
                end else if (miss_right) begin
                    score_l_d = inc_l;
                    dir_d     = 1'b1;
                    if (inc_l == WIN_VAL) begin
                        state_d  = S_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = S_POINT;
                        cnt_d   = POINT_CNT;
                    end
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == 8'd1) begin
                        state_d = S_SERVE;
                        cnt_d   = SERVE_CNT;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Button history is sampled even during reset so a button held across
    // reset does not look like a fresh press afterwards.
    always_ff @(posedge clock) begin
        start_q <= start_btn;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            winner_q   <= 2'b00;
            dir_q      <= 1'b1;
            paddle_q   <= 1'b0;
            ball_rst_q <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            dir_q      <= dir_d;
            // Block controls are decoded from the next state so they change
            // on the same edge as state.
            paddle_q   <= (state_d != S_IDLE);
            ball_rst_q <= (state_d == S_PLAY);
            enable_q   <= (state_d == S_PLAY);
        end
    end

    assign state        = state_q;
    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign winner       = winner_q;
    assign serve_dir    = dir_q;
    assign paddle_rst_n = paddle_q;
    assign ball_rst_n   = ball_rst_q;
    assign ball_enable  = enable_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       paddle_rst_n, ball_rst_n, ball_enable, serve_dir;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    pong_game_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .paddle_rst_n(paddle_rst_n),
        .ball_rst_n  (ball_rst_n),
        .ball_enable (ball_enable),
        .serve_dir   (serve_dir),
        .score_l     (score_l),
        .score_r     (score_r),
        .winner      (winner),
        .state       (state)
    );

    always #5 clock = ~clock;

    // Reference model: game phase plus frames still to wait in it.
    int m_phase = 0;   // 0 idle, 1 serve, 2 play, 3 point, 4 over
    int m_left = 0;    // frame ticks still needed to leave serve/point
    int m_sl = 0, m_sr = 0, m_win = 0, m_dir = 1;
    bit m_prev_btn = 0;
    bit m_valid = 0;

    always @(posedge clock) begin
        bit pressed;
        pressed = start_btn && !m_prev_btn;
        m_prev_btn = start_btn;
        if (reset) begin
            m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1;
            m_valid = 1;
        end else if ((m_phase == 0 || m_phase == 4) && pressed) begin
            m_phase = 1; m_left = 60; m_sl = 0; m_sr = 0; m_win = 0;
        end else if ((m_phase == 1 || m_phase == 3) && frame_tick) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_phase == 1) m_phase = 2;
                else begin m_phase = 1; m_left = 60; end
            end
        end else if (m_phase == 2 && (miss_left || miss_right)) begin
            if (miss_left && miss_right) begin
                m_phase = 3; m_left = 30;
            end else if (miss_left) begin
                m_sr = m_sr + 1; m_dir = 0;
                if (m_sr == 7) begin m_phase = 4; m_win = 2; end
                else begin m_phase = 3; m_left = 30; end
            end else begin
                m_sl = m_sl + 1; m_dir = 1;
                if (m_sl == 7) begin m_phase = 4; m_win = 1; end
                else begin m_phase = 3; m_left = 30; end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("state", int'(state), m_phase);
            check("score_l", int'(score_l), m_sl);
            check("score_r", int'(score_r), m_sr);
            check("winner", int'(winner), m_win);
            check("serve_dir", int'(serve_dir), m_dir);
            check("paddle_rst_n", int'(paddle_rst_n), int'(m_phase != 0));
            check("ball_rst_n", int'(ball_rst_n), int'(m_phase == 2));
            check("ball_enable", int'(ball_enable), int'(m_phase == 2));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        cyc(n);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_miss(input bit l, input bit r);
        miss_left = l; miss_right = r;
        cyc(1);
        miss_left = 1'b0; miss_right = 1'b0;
    endtask

    task automatic press;
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        check("lit reset state", int'(state), 0);
        check("lit reset dir", int'(serve_dir), 1);
        cyc(1);

        press();
        check("lit serve state", int'(state), 1);
        check("lit serve ball_rst_n", int'(ball_rst_n), 0);
        ticks(59);
        check("lit serve after 59", int'(state), 1);
        ticks(1);
        check("lit play state", int'(state), 2);
        check("lit play enable", int'(ball_enable), 1);

        pulse_miss(0, 1);
        check("lit score_l", int'(score_l), 1);
        check("lit point state", int'(state), 3);
        ticks(30);
        check("lit back to serve", int'(state), 1);
        ticks(60);
        check("lit play again", int'(state), 2);

        // Right player to six points, then the winning point.
        for (int i = 0; i < 6; i++) begin
            pulse_miss(1, 0);
            ticks(30);
            ticks(60);
        end
        check("lit score_r six", int'(score_r), 6);
        pulse_miss(1, 0);
        check("lit score_r win", int'(score_r), 7);
        check("lit winner", int'(winner), 2);
        check("lit over state", int'(state), 4);
        pulse_miss(1, 1);
        pulse_miss(0, 1);
        check("lit over hold", int'(score_r), 7);

        start_btn = 1'b1;
        cyc(5);
        start_btn = 1'b0;
        check("lit restart state", int'(state), 1);
        check("lit restart score", int'(score_r), 0);
        check("lit restart winner", int'(winner), 0);

        ticks(60);
        pulse_miss(1, 1);
        check("lit replay state", int'(state), 3);
        check("lit replay score", int'(score_l), 0);
        ticks(30);
        pulse_miss(1, 0);
        check("lit serve ignores miss", int'(score_r), 0);

        // Reach a point pause with score_l=3, then reset mid-pause.
        for (int i = 0; i < 3; i++) begin
            ticks(60);
            pulse_miss(0, 1);
            if (i < 2) ticks(30);
        end
        check("lit point score_l", int'(score_l), 3);
        reset = 1'b1;
        start_btn = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("lit rst state", int'(state), 0);
        check("lit rst score_l", int'(score_l), 0);
        check("lit rst paddle", int'(paddle_rst_n), 0);
        cyc(3);
        check("lit held btn no start", int'(state), 0);
        start_btn = 1'b0;
        cyc(1);
        press();
        check("lit press after release", int'(state), 1);

        // Random play checked by the model on every cycle.
        for (int i = 0; i < 30000; i++) begin
            frame_tick = ($urandom_range(0, 1) == 0);
            miss_left  = ($urandom_range(0, 9) == 0);
            miss_right = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
            reset = ($urandom_range(0, 4999) == 0);
            cyc(1);
        end
        reset = 1'b0; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
